// File: rtl/voice_rec_pkg.sv
// Shared definitions for the voice recorder: clip-timer state encoding,
// Controller memory-select bit positions and derived timing constants.
package voice_rec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } clip_state_t;

    // Bit positions inside memoryselect_clip_1, also used by the Controller.
    localparam int MSEL_BLOCK = 1;
    localparam int MSEL_WR    = 0;

    // System clock cycles per sample.
    function automatic int div_of(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

    // Samples in one clip.
    function automatic int samples_of(input int sample_hz, input int clip_seconds);
        return sample_hz * clip_seconds;
    endfunction

    // Address width covering two clip blocks.
    function automatic int addr_w_of(input int samples);
        return $clog2(2 * samples);
    endfunction

    // Sample index width; never narrower than one bit.
    function automatic int idx_w_of(input int samples);
        return (samples > 1) ? $clog2(samples) : 1;
    endfunction

endpackage

// File: rtl/clip_timer_if.sv
// Controller <-> clip timer bundle: run enable and block/direction select in,
// per-sample memory strobes, address and status out.
interface clip_timer_if #(
    parameter int ADDR_W = 15
);
    logic              timer;
    logic [1:0]        memoryselect_clip_1;
    logic              seconds2;
    logic              sample_tick;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] address;
    logic              busy;

    // Controller side.
    modport master (
        output timer, memoryselect_clip_1,
        input  seconds2, sample_tick, mem_we, mem_re, address, busy
    );

    // Clip timer side.
    modport slave (
        input  timer, memoryselect_clip_1,
        output seconds2, sample_tick, mem_we, mem_re, address, busy
    );
endinterface

// File: rtl/sample_div.sv
// Modulo-DIV cycle counter. While enabled it counts 0..DIV-1 and flags the
// terminal count; clear forces it back to 0 and has priority over enable.
module sample_div #(
    parameter int DIV = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int              CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Wrap-around divider counter.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state updates use <= so every register samples pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/clip_timer.sv
// Clip timer: paces one clip of SAMPLES samples at SAMPLE_HZ, producing the
// per-sample memory address and read/write strobe, and raises seconds2 once
// the whole clip has been transferred.
module clip_timer
    import voice_rec_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SAMPLE_HZ    = 8_000,
    parameter int CLIP_SECONDS = 2
) (
    input logic         clock,
    input logic         reset,
    clip_timer_if.slave bus
);
    localparam int DIV     = div_of(CLK_HZ, SAMPLE_HZ);
    localparam int SAMPLES = samples_of(SAMPLE_HZ, CLIP_SECONDS);
    localparam int ADDR_W  = addr_w_of(SAMPLES);
    localparam int IDX_W   = idx_w_of(SAMPLES);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(SAMPLES - 1);
    localparam logic [ADDR_W-1:0] BLOCK1_BASE = ADDR_W'(SAMPLES);

    clip_state_t      state;
    logic [IDX_W-1:0] idx;
    logic             blk;
    logic             wr;
    logic             div_clear;
    logic             div_en;
    logic             tc;

    // The divider only runs in RUN and restarts from 0 on every RUN entry.
    assign div_clear = (state != RUN);
    assign div_en    = (state == RUN);

    sample_div #(
        .DIV(DIV)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .clear  (div_clear),
        .enable (div_en),
        .tc     (tc)
    );

    // Clip FSM with registered strobes, address and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            blk             <= 1'b0;
            wr              <= 1'b0;
            bus.seconds2    <= 1'b0;
            bus.sample_tick <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_re      <= 1'b0;
            bus.address     <= '0;
            bus.busy        <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle, so a tick lasts exactly one cycle.
            bus.sample_tick <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_re      <= 1'b0;

            unique case (state)
                IDLE: begin
                    bus.seconds2 <= 1'b0;
                    if (bus.timer) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        blk      <= bus.memoryselect_clip_1[MSEL_BLOCK];
                        wr       <= bus.memoryselect_clip_1[MSEL_WR];
                        idx      <= '0;
                    end
                end

                RUN: begin
                    if (!bus.timer) begin
                        // Abort beats a coincident tick.
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (tc) begin
                        bus.sample_tick <= 1'b1;
                        bus.mem_we      <= wr;
                        bus.mem_re      <= !wr;
                        bus.address     <= (blk ? BLOCK1_BASE : '0) + ADDR_W'(idx);
                        idx             <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    // Only a low timer leaves DONE; a held-high timer keeps the flag up.
                    if (!bus.timer) begin
                        state        <= IDLE;
                        bus.seconds2 <= 1'b0;
                    end else begin
                        bus.seconds2 <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_timer.sv
// Randomised scoreboard bench for clip_timer with DIV=5, SAMPLES=8.
module tb_clip_timer;
    import voice_rec_pkg::*;

    localparam int CLK_HZ       = 20;
    localparam int SAMPLE_HZ    = 4;
    localparam int CLIP_SECONDS = 2;
    localparam int DIV          = 5;
    localparam int SAMPLES      = 8;
    localparam int ADDR_W       = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    clip_timer_if #(.ADDR_W(ADDR_W)) bus ();

    clip_timer #(
        .CLK_HZ       (CLK_HZ),
        .SAMPLE_HZ    (SAMPLE_HZ),
        .CLIP_SECONDS (CLIP_SECONDS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int addr;
        int we;
    } tick_t;

    tick_t tick_q[$];
    int    done_q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  prev_s2  = 1'b0;
    tick_t mon_e;

    // Rising-edge counter; the driver and monitor use it as the time base.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_tick"},     int'(bus.sample_tick), 0);
        check({tag, "_we"},       int'(bus.mem_we),      0);
        check({tag, "_re"},       int'(bus.mem_re),      0);
        check({tag, "_address"},  int'(bus.address),     0);
        check({tag, "_seconds2"}, int'(bus.seconds2),    0);
        check({tag, "_busy"},     int'(bus.busy),        0);
    endtask

    // Runs one clip. The model: ticks at edges n0+DIV*k (k=1..SAMPLES) at
    // address block_base+k-1; a timer drop seen at edge p+1 keeps only the
    // ticks at edges <= p; a full clip raises seconds2 one edge after the
    // last tick. mode: 0 msel steady, 1 random msel churn, 2 switch to 2'b11.
    task automatic run_clip(input logic [1:0] msel, input int abort_at,
                            input int hold, input int mode);
        int    n0;
        int    p;
        int    base;
        int    last_tick;
        tick_t e;
        base      = msel[1] ? SAMPLES : 0;
        bus.memoryselect_clip_1 = msel;
        bus.timer = 1'b1;
        n0        = cyc + 1;
        last_tick = n0 + DIV * SAMPLES;
        p         = (abort_at < 0) ? last_tick + hold : n0 + abort_at;
        for (int k = 1; k <= SAMPLES; k++) begin
            if (n0 + DIV * k <= p) begin
                e.cyc  = n0 + DIV * k;
                e.addr = base + k - 1;
                e.we   = int'(msel[0]);
                tick_q.push_back(e);
            end
        end
        if (abort_at < 0) done_q.push_back(last_tick + 1);
        while (cyc < p) begin
            step();
            if (cyc == n0) check("busy_run", int'(bus.busy), 1);
            if (abort_at < 0 && cyc > last_tick) begin
                check("seconds2_hold", int'(bus.seconds2), 1);
                check("busy_done", int'(bus.busy), 0);
            end
            if (mode == 1 && $urandom_range(0, 3) == 0)
                bus.memoryselect_clip_1 = 2'($urandom_range(0, 3));
            if (mode == 2 && cyc == n0 + 12)
                bus.memoryselect_clip_1 = 2'b11;
        end
        bus.timer = 1'b0;
        step();
        check("seconds2_low", int'(bus.seconds2), 0);
        check("busy_low", int'(bus.busy), 0);
    endtask

    // Monitor: pops the scoreboard on every tick and every seconds2 rise.
    always @(negedge clock) begin
        if (reset) begin
            prev_s2 <= 1'b0;
        end else begin
            check("strobe_gate", int'((bus.mem_we | bus.mem_re) & ~bus.sample_tick), 0);
            check("we_re_excl", int'(bus.mem_we & bus.mem_re), 0);
            if (bus.sample_tick) begin
                if (tick_q.size() == 0) begin
                    check("unexpected_tick", 1, 0);
                end else begin
                    mon_e = tick_q.pop_front();
                    check("tick_cycle", cyc, mon_e.cyc);
                    check("tick_address", int'(bus.address), mon_e.addr);
                    check("tick_we", int'(bus.mem_we), mon_e.we);
                    check("tick_re", int'(bus.mem_re), 1 - mon_e.we);
                end
            end
            if (bus.seconds2 && !prev_s2) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            prev_s2 <= bus.seconds2;
        end
    end

    initial begin
        int          n0;
        tick_t       e;
        logic [1:0]  msel_r;
        int          abort_r;

        bus.timer = 1'b0;
        bus.memoryselect_clip_1 = 2'b00;
        reset = 1'b1;
        step();
        step();
        outputs_zero("por");
        reset = 1'b0;
        step();

        // Asynchronous reset in the middle of a block-1 write clip.
        bus.memoryselect_clip_1 = 2'b11;
        bus.timer = 1'b1;
        n0 = cyc + 1;
        for (int k = 1; k <= 2; k++) begin
            e.cyc  = n0 + DIV * k;
            e.addr = SAMPLES + k - 1;
            e.we   = 1;
            tick_q.push_back(e);
        end
        while (cyc < n0 + 12) step();
        #2;
        reset = 1'b1;
        bus.timer = 1'b0;
        #1;
        outputs_zero("async_rst");
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        outputs_zero("post_rst");

        // Directed clips.
        run_clip(2'b01, -1, 1, 0);
        run_clip(2'b10, -1, 2, 0);
        run_clip(2'b01, 3 * DIV, 1, 0);
        run_clip(2'b01, -1, 1, 0);
        run_clip(2'b10, 4 * DIV - 1, 1, 0);
        run_clip(2'b01, -1, 1, 2);
        run_clip(2'b00, -1, 10, 0);
        run_clip(2'b11, -1, 1, 0);

        // Random clips: random block/direction, abort point and msel churn.
        for (int i = 0; i < 12; i++) begin
            msel_r  = 2'($urandom_range(0, 3));
            abort_r = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DIV * SAMPLES - 1));
            run_clip(msel_r, abort_r, int'($urandom_range(1, 4)), 1);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (DIV * 2) step();
        check("tick_q_empty", tick_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
